// File: rtl/fneg_unit.sv
// fneg_unit: binary32 sign-manipulation unit (FNEG / FABS / FMOV / FNABS)
// with operand class flags and a one-stage valid/ready output register.
// Optional build macro: FNEG_NAN_CANON_EN. When it is defined, every NaN
// operand produces the canonical quiet NaN 32'h7FC00000.
module fneg_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op,
  input  logic [1:0]  funct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_denorm
);

  localparam logic [1:0] FN_NEG  = 2'b00;
  localparam logic [1:0] FN_ABS  = 2'b01;
  localparam logic [1:0] FN_MOV  = 2'b10;
  localparam logic [1:0] FN_NABS = 2'b11;

  logic        r_out_valid;
  logic [31:0] r_result;
  logic        r_is_zero;
  logic        r_is_inf;
  logic        r_is_nan;
  logic        r_is_denorm;

  logic        w_accept;
  logic        w_sign;
  logic        w_exp_zero;
  logic        w_exp_ones;
  logic        w_frac_zero;
  logic [31:0] w_result;

  // The slot can take a new operand when it is empty or being drained this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Classify the incoming operand and form the sign-adjusted result.
  always_comb begin
    w_sign      = op[31];
    w_exp_zero  = (op[30:23] == 8'h00);
    w_exp_ones  = (op[30:23] == 8'hFF);
    w_frac_zero = (op[22:0] == 23'h0);
    case (funct)
      FN_NEG:  w_sign = ~op[31];
      FN_ABS:  w_sign = 1'b0;
      FN_MOV:  w_sign = op[31];
      FN_NABS: w_sign = 1'b1;
      default: w_sign = op[31];
    endcase
    w_result = {w_sign, op[30:0]};
`ifdef FNEG_NAN_CANON_EN
    // Any NaN, whatever its sign or payload, collapses to the canonical quiet NaN.
    if (w_exp_ones && !w_frac_zero) begin
      w_result = 32'h7FC0_0000;
    end
`endif
  end

  // Output stage: load only on an accepted operand; valid drops when drained with nothing new.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_result    <= 32'h0;
      r_is_zero   <= 1'b0;
      r_is_inf    <= 1'b0;
      r_is_nan    <= 1'b0;
      r_is_denorm <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_result    <= w_result;
        r_is_zero   <= w_exp_zero && w_frac_zero;
        r_is_inf    <= w_exp_ones && w_frac_zero;
        r_is_nan    <= w_exp_ones && !w_frac_zero;
        r_is_denorm <= w_exp_zero && !w_frac_zero;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign is_zero   = r_is_zero;
  assign is_inf    = r_is_inf;
  assign is_nan    = r_is_nan;
  assign is_denorm = r_is_denorm;

endmodule

// File: tb/tb_fneg_unit.sv
// Self-checking bench for fneg_unit: expected results are queued when an
// operand is accepted and compared when the result is handed over.
module tb_fneg_unit;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op;
  logic [1:0]  funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        is_zero;
  logic        is_inf;
  logic        is_nan;
  logic        is_denorm;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;   // {zero, inf, nan, denorm}
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fneg_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .is_zero   (is_zero),
    .is_inf    (is_inf),
    .is_nan    (is_nan),
    .is_denorm (is_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour built from the binary32 field definitions.
  function automatic exp_t model(input logic [31:0] a, input logic [1:0] fn);
    exp_t e;
    logic s;
    case (fn)
      2'b00:   s = ~a[31];
      2'b01:   s = 1'b0;
      2'b10:   s = a[31];
      default: s = 1'b1;
    endcase
    e.res    = {s, a[30:0]};
    e.flg[3] = (a[30:23] == 8'h00) && (a[22:0] == 23'h0);
    e.flg[2] = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    e.flg[1] = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    e.flg[0] = (a[30:23] == 8'h00) && (a[22:0] != 23'h0);
`ifdef FNEG_NAN_CANON_EN
    if (e.flg[1]) e.res = 32'h7FC0_0000;
`endif
    return e;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; op = 32'h0; funct = 2'b00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({out_valid, result, is_zero, is_inf, is_nan, is_denorm} !== 37'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%b result=%h flags=%b%b%b%b want 0/00000000/0000",
               out_valid, result, is_zero, is_inf, is_nan, is_denorm);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    $display("reset: checked outputs and in_ready");
  endtask

  task automatic test_vectors();
    localparam int N = 12;
    logic [31:0] v_op  [N];
    logic [1:0]  v_fn  [N];
    logic [31:0] v_res [N];
    logic [3:0]  v_flg [N];
    logic [31:0] nan_a, nan_b;
    exp_t e;
    int   k;
`ifdef FNEG_NAN_CANON_EN
    nan_a = 32'h7FC0_0000; nan_b = 32'h7FC0_0000;
`else
    nan_a = 32'hFFC0_0001; nan_b = 32'h7FC0_0001;
`endif
    v_op[0]  = 32'h0000_0000; v_fn[0]  = 2'b00; v_res[0]  = 32'h8000_0000; v_flg[0]  = 4'b1000;
    v_op[1]  = 32'h8000_0000; v_fn[1]  = 2'b00; v_res[1]  = 32'h0000_0000; v_flg[1]  = 4'b1000;
    v_op[2]  = 32'h3F80_0000; v_fn[2]  = 2'b00; v_res[2]  = 32'hBF80_0000; v_flg[2]  = 4'b0000;
    v_op[3]  = 32'hBF80_0000; v_fn[3]  = 2'b01; v_res[3]  = 32'h3F80_0000; v_flg[3]  = 4'b0000;
    v_op[4]  = 32'h3F80_0000; v_fn[4]  = 2'b11; v_res[4]  = 32'hBF80_0000; v_flg[4]  = 4'b0000;
    v_op[5]  = 32'hC049_0FDB; v_fn[5]  = 2'b10; v_res[5]  = 32'hC049_0FDB; v_flg[5]  = 4'b0000;
    v_op[6]  = 32'hFF80_0000; v_fn[6]  = 2'b00; v_res[6]  = 32'h7F80_0000; v_flg[6]  = 4'b0100;
    v_op[7]  = 32'h0000_0001; v_fn[7]  = 2'b00; v_res[7]  = 32'h8000_0001; v_flg[7]  = 4'b0001;
    v_op[8]  = 32'h7FC0_0001; v_fn[8]  = 2'b00; v_res[8]  = nan_a;         v_flg[8]  = 4'b0010;
    v_op[9]  = 32'hFFC0_0001; v_fn[9]  = 2'b01; v_res[9]  = nan_b;         v_flg[9]  = 4'b0010;
    v_op[10] = 32'h8000_0000; v_fn[10] = 2'b11; v_res[10] = 32'h8000_0000; v_flg[10] = 4'b1000;
    v_op[11] = 32'h7F80_0000; v_fn[11] = 2'b10; v_res[11] = 32'h7F80_0000; v_flg[11] = 4'b0100;
    k = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      in_valid  = (i < N);
      op        = (i < N) ? v_op[i] : 32'h0;
      funct     = (i < N) ? v_fn[i] : 2'b00;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== (sb_q.size() != 0)) begin
        n_bad++;
        $display("FAIL vec_out_valid cycle=%0d got=%b want=%b", i, out_valid, sb_q.size() != 0);
      end
      if (out_valid && out_ready && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({result, is_zero, is_inf, is_nan, is_denorm} !== {e.res, e.flg}) begin
          n_bad++;
          $display("FAIL vec_result idx=%0d got=%h flags=%b%b%b%b want=%h flags=%b",
                   k, result, is_zero, is_inf, is_nan, is_denorm, e.res, e.flg);
        end else begin
          $display("vector %0d: result=%h flags=%b", k, result, e.flg);
        end
        k++;
      end
      if (in_valid && in_ready) sb_q.push_back({v_res[i], v_flg[i]});
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] op_a, op_b;
    exp_t ea, eb, e;
    op_a = 32'h4048_F5C3; op_b = 32'hC2F6_0000;
    ea = model(op_a, 2'b00);
    eb = model(op_b, 2'b01);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid  = (i < 5);
      op        = (i == 0) ? op_a : op_b;
      funct     = (i == 0) ? 2'b00 : 2'b01;
      out_ready = (i >= 4);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_bad++;
        $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", i, in_ready, !out_valid || out_ready);
      end
      if (i >= 1 && i <= 3) begin
        n_cmp++;
        if ({out_valid, in_ready, result, is_zero, is_inf, is_nan, is_denorm} !== {2'b10, ea.res, ea.flg}) begin
          n_bad++;
          $display("FAIL bp_hold cycle=%0d got valid=%b in_ready=%b result=%h want valid=1 in_ready=0 result=%h",
                   i, out_valid, in_ready, result, ea.res);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({out_valid, result, is_zero, is_inf, is_nan, is_denorm} !== {1'b0, eb.res, eb.flg}) begin
          n_bad++;
          $display("FAIL bp_idle_keep got valid=%b result=%h want valid=0 result=%h",
                   out_valid, result, eb.res);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_unexpected_output cycle=%0d got=%h want=none", i, result);
        end else begin
          e = sb_q.pop_front();
          if ({result, is_zero, is_inf, is_nan, is_denorm} !== {e.res, e.flg}) begin
            n_bad++;
            $display("FAIL bp_result cycle=%0d got=%h want=%h", i, result, e.res);
          end else begin
            $display("backpressure cycle %0d: drained %h", i, result);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back((i == 0) ? ea : eb);
      @(posedge clk);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_leftover got=%0d want=0", sb_q.size());
    end
  endtask

  task automatic test_random_fneg();
    exp_t e;
    int   n_ok;
    n_ok = 0;
    for (int i = 0; i < 10003; i++) begin
      @(negedge clk);
      if (i == 5000) begin
        rstn = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, result, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
          n_bad++;
          $display("FAIL rand_mid_reset got valid=%b result=%h in_ready=%b want 0/00000000/1",
                   out_valid, result, in_ready);
        end else begin
          $display("random: mid-stream reset cleared output");
        end
        sb_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        continue;
      end
      in_valid  = (i < 10000);
      op        = $urandom;
      funct     = 2'b00;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== (sb_q.size() != 0) || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_handshake cycle=%0d got valid=%b in_ready=%b want valid=%b in_ready=1",
                 i, out_valid, in_ready, sb_q.size() != 0);
      end
      if (out_valid && out_ready && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({result, is_zero, is_inf, is_nan, is_denorm} !== {e.res, e.flg}) begin
          n_bad++;
          $display("FAIL rand_result cycle=%0d got=%h flags=%b%b%b%b want=%h flags=%b",
                   i, result, is_zero, is_inf, is_nan, is_denorm, e.res, e.flg);
        end else begin
          n_ok++;
        end
      end
      if (in_valid && in_ready) begin
        e = model(op, 2'b00);
        e.res = op ^ 32'h8000_0000;
`ifdef FNEG_NAN_CANON_EN
        if (e.flg[1]) e.res = 32'h7FC0_0000;
`endif
        sb_q.push_back(e);
      end
      @(posedge clk);
    end
    $display("random FNEG: %0d results matched", n_ok);
  endtask

  task automatic test_random_handshake();
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = (i < 395) ? ($urandom_range(0, 3) != 0) : 1'b0;
      op        = $urandom;
      if ($urandom_range(0, 7) == 0) op[30:23] = 8'hFF;
      if ($urandom_range(0, 7) == 0) op[30:23] = 8'h00;
      if ($urandom_range(0, 7) == 0) op[22:0]  = 23'h0;
      funct     = 2'($urandom_range(0, 3));
      out_ready = (i >= 395) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready) || out_valid !== (sb_q.size() != 0)) begin
        n_bad++;
        $display("FAIL hs_ctrl cycle=%0d got valid=%b in_ready=%b want valid=%b in_ready=%b",
                 i, out_valid, in_ready, sb_q.size() != 0, !out_valid || out_ready);
      end
      if (out_valid && out_ready && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({result, is_zero, is_inf, is_nan, is_denorm} !== {e.res, e.flg}) begin
          n_bad++;
          $display("FAIL hs_result cycle=%0d got=%h flags=%b%b%b%b want=%h flags=%b",
                   i, result, is_zero, is_inf, is_nan, is_denorm, e.res, e.flg);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(op, funct));
      @(posedge clk);
    end
    $display("random handshake: done");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random_fneg();
    test_random_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
